column_scan_scheduler: RTL and testbench

Sequences the per-column frame generator for the rotating 3D display.
- Measures rotor period from a once-per-revolution index pulse and divides each revolution into ROTATIONAL_RES angular slices.
- Drives the discretized angle dtheta and, per slice, sweeps SCAN_RATE mirrored column-index pairs into the frame generator.
- Hands each pair to the panel driver over a valid/ready handshake.
- Sits between the hall/index sensor synchronizer and the frame generator / HUB75 driver.

---
 rtl/display_pkg.sv | 13 +
 rtl/rotor_period_timer.sv | 66 ++++++
 rtl/column_scan_scheduler.sv | 120 ++++++++++++
 tb/tb_column_scan_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display geometry defaults and scan types
package display_pkg;
    localparam int DEFAULT_ROTATIONAL_RES = 256;
    localparam int DEFAULT_SCAN_RATE      = 32;
    localparam int DEFAULT_NUM_COLS       = 64;
    localparam int DEFAULT_NUM_ROWS       = 32;
    localparam int DEFAULT_RGB_RES        = 8;
    localparam int DEFAULT_PERIOD_W       = 32;

    typedef logic [$clog2(DEFAULT_ROTATIONAL_RES)-1:0] dtheta_t;

    typedef enum logic [1:0] {IDLE, SWEEP, WAIT} scan_state_t;
endpackage

// File: rtl/rotor_period_timer.sv
// rtl/rotor_period_timer.sv - rotor period measurement, angular slice timer and stall detect
module rotor_period_timer #(
    parameter int ROTATIONAL_RES = 256,
    parameter int PERIOD_W       = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              index_pulse,
    output logic                              slice_start,
    output logic [$clog2(ROTATIONAL_RES)-1:0] dcount,
    output logic                              spinning,
    output logic                              stall
);
    localparam int RES_W = $clog2(ROTATIONAL_RES);

    logic [PERIOD_W-1:0] pcnt, pcnt_inc, period_q, slice_raw, slice_len, stimer;
    logic                armed, period_valid, pcnt_sat, restart, expiry;

    // pcnt_inc is the number of clocks since the previous pulse, so it is what gets latched
    assign pcnt_sat    = &pcnt;
    assign pcnt_inc    = pcnt_sat ? pcnt : pcnt + PERIOD_W'(1);
    assign slice_raw   = period_q >> RES_W;
    assign slice_len   = (slice_raw == '0) ? PERIOD_W'(1) : slice_raw;
    assign stall       = pcnt_sat && !index_pulse;
    assign restart     = index_pulse && armed;
    assign expiry      = period_valid && !stall && (stimer == slice_len - PERIOD_W'(1));
    assign slice_start = restart || expiry;
    assign spinning    = period_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt         <= '0;
            period_q     <= '0;
            stimer       <= '0;
            dcount       <= '0;
            armed        <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            pcnt <= index_pulse ? '0 : pcnt_inc;

            // the first pulse after reset or stall only opens a measurement window
            if (index_pulse) begin
                armed <= 1'b1;
                if (armed) begin
                    period_q     <= pcnt_inc;
                    period_valid <= 1'b1;
                end
            end else if (stall) begin
                armed        <= 1'b0;
                period_valid <= 1'b0;
            end

            if (restart) begin
                stimer <= '0;
                dcount <= '0;
            end else if (expiry) begin
                stimer <= '0;
                if (!(&dcount)) begin
                    dcount <= dcount + RES_W'(1);
                end
            end else if (period_valid && !stall) begin
                stimer <= stimer + PERIOD_W'(1);
            end
        end
    end
endmodule

// File: rtl/column_scan_scheduler.sv
// rtl/column_scan_scheduler.sv - per-slice mirrored column pair sweep for the rotating display
// Optional PHASE_OFFSET_EN adds phase_offset_in, added to the slice count on dtheta_out.
module column_scan_scheduler
    import display_pkg::*;
#(
    parameter int ROTATIONAL_RES = DEFAULT_ROTATIONAL_RES,
    parameter int SCAN_RATE      = DEFAULT_SCAN_RATE,
    parameter int NUM_COLS       = DEFAULT_NUM_COLS,
    parameter int PERIOD_W       = DEFAULT_PERIOD_W
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              index_pulse_in,
    input  logic                              ready_in,
`ifdef PHASE_OFFSET_EN
    input  logic [$clog2(ROTATIONAL_RES)-1:0] phase_offset_in,
`endif
    output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta_out,
    output logic [$clog2(SCAN_RATE)-1:0]      column_index1_out,
    output logic [$clog2(SCAN_RATE):0]        column_index2_out,
    output logic                              valid_out,
    output logic                              spinning_out,
    output logic                              overrun_out
);
    localparam int RES_W = $clog2(ROTATIONAL_RES);
    localparam int IDX_W = $clog2(SCAN_RATE);
    localparam int MIR_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(SCAN_RATE - 1);
    localparam logic [MIR_W-1:0] FIRST_MIRROR = MIR_W'(NUM_COLS - 1);

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [MIR_W-1:0] mirror_q, mirror_d;
    logic             overrun_q, overrun_d;
    logic             slice_start, stall, spinning;
    logic [RES_W-1:0] dcount;

    rotor_period_timer #(
        .ROTATIONAL_RES(ROTATIONAL_RES),
        .PERIOD_W      (PERIOD_W)
    ) u_timer (
        .clk        (clk_in),
        .rst        (rst_in),
        .index_pulse(index_pulse_in),
        .slice_start(slice_start),
        .dcount     (dcount),
        .spinning   (spinning),
        .stall      (stall)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mirror_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mirror_q  <= mirror_d;
            overrun_q <= overrun_d;
        end
    end

    // a new slice always restarts the sweep, dropping any pair still waiting for ready
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mirror_d  = mirror_q;
        overrun_d = overrun_q;
        if (stall) begin
            state_d = IDLE;
        end else if (slice_start) begin
            if (state_q == SWEEP) begin
                overrun_d = 1'b1;
            end
            state_d  = SWEEP;
            idx_d    = '0;
            mirror_d = FIRST_MIRROR;
        end else begin
            case (state_q)
                SWEEP: begin
                    if (ready_in) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = WAIT;
                        end else begin
                            idx_d    = idx_q + IDX_W'(1);
                            mirror_d = mirror_q - MIR_W'(1);
                        end
                    end
                end
                IDLE, WAIT: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef PHASE_OFFSET_EN
    logic [RES_W-1:0] phase_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase_q <= '0;
        end else if (slice_start) begin
            phase_q <= phase_offset_in;
        end
    end

    assign dtheta_out = dcount + phase_q;
`else
    assign dtheta_out = dcount;
`endif

    assign valid_out         = (state_q == SWEEP);
    assign column_index1_out = idx_q;
    assign column_index2_out = mirror_q;
    assign spinning_out      = spinning;
    assign overrun_out       = overrun_q;
endmodule

// File: tb/tb_column_scan_scheduler.sv
// tb/tb_column_scan_scheduler.sv - randomized self-checking bench for column_scan_scheduler
`timescale 1ns/1ps
module tb_column_scan_scheduler;
    localparam int RES  = 4;
    localparam int SCAN = 4;
    localparam int COLS = 8;
    localparam int PW   = 10;
    localparam int SAT  = (1 << PW) - 1;

    logic       clk = 1'b0;
    logic       rst_in, index_pulse_in, ready_in;
    logic [1:0] dtheta_out, column_index1_out;
    logic [2:0] column_index2_out;
    logic       valid_out, spinning_out, overrun_out;
`ifdef PHASE_OFFSET_EN
    logic [1:0] phase_offset_in;
`endif
    logic [9:0] act;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0, ref_edge = 0, pulse_edge = 0, period = 0;
    int m_slice = 0, m_phase = 0, phase_in = 0;
    bit armed = 0, running = 0, m_over = 0;
    int q[$];

    always #5 clk = ~clk;

    column_scan_scheduler #(
        .ROTATIONAL_RES(RES),
        .SCAN_RATE     (SCAN),
        .NUM_COLS      (COLS),
        .PERIOD_W      (PW)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .index_pulse_in   (index_pulse_in),
        .ready_in         (ready_in),
`ifdef PHASE_OFFSET_EN
        .phase_offset_in  (phase_offset_in),
`endif
        .dtheta_out       (dtheta_out),
        .column_index1_out(column_index1_out),
        .column_index2_out(column_index2_out),
        .valid_out        (valid_out),
        .spinning_out     (spinning_out),
        .overrun_out      (overrun_out)
    );

    assign act = {valid_out, spinning_out, overrun_out, dtheta_out, column_index1_out, column_index2_out};

    // Reference: slices fall at whole multiples of period/RES after the starting pulse,
    // and each slice replaces the pending work with the full list of SCAN pair indices.
    function automatic logic [9:0] m_vec();
        logic [9:0] v;
        int d;
        d = (m_slice + m_phase) % RES;
        v = {q.size() > 0, running, m_over, 2'(d), 5'b0};
        if (q.size() > 0) begin
            v[4:3] = 2'(q[0]);
            v[2:0] = 3'(COLS - 1 - q[0]);
        end
        return v;
    endfunction

    function automatic logic [9:0] m_mask();
        return (q.size() > 0) ? 10'h3FF : 10'h3E0;
    endfunction

    task automatic step(input bit p, input bit r, input bit rs);
        int k, len;
        bit slice;
        index_pulse_in = p;
        ready_in       = r;
        rst_in         = rs;
`ifdef PHASE_OFFSET_EN
        phase_offset_in = 2'(phase_in);
`endif
        @(posedge clk);
        cyc++;
        slice = 0;
        if (rs) begin
            armed = 0; running = 0; m_over = 0; m_slice = 0; m_phase = 0;
            ref_edge = cyc;
            q.delete();
        end else begin
            if (p) begin
                if (armed) begin
                    period     = (cyc - ref_edge > SAT) ? SAT : cyc - ref_edge;
                    running    = 1;
                    pulse_edge = cyc;
                    m_slice    = 0;
                    slice      = 1;
                end
                armed    = 1;
                ref_edge = cyc;
            end else if (cyc - ref_edge > SAT) begin
                armed = 0; running = 0;
                q.delete();
            end else if (running) begin
                len = (period / RES == 0) ? 1 : period / RES;
                k   = cyc - pulse_edge;
                if (k % len == 0) begin
                    slice   = 1;
                    m_slice = (k / len > RES - 1) ? RES - 1 : k / len;
                end
            end
            if (slice) begin
                if (q.size() > 0) m_over = 1;
                q.delete();
                for (int i = 0; i < SCAN; i++) q.push_back(i);
                m_phase = phase_in;
            end else if (q.size() > 0 && r) begin
                void'(q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) step(0, 0, 1);
        n_cmp++;
        if (act !== 10'h000) begin
            n_bad++; $display("FAIL reset_state got %h exp %h", act, 10'h000);
        end
        step(0, 1, 0);
        n_cmp++;
        if ((act & m_mask()) !== m_vec()) begin
            n_bad++; $display("FAIL reset_idle cyc=%0d got %h exp %h", cyc, act, m_vec());
        end
    endtask

    task automatic test_basic_sweep();
        repeat (2) step(0, 0, 1);
        for (int t = 0; t <= 1250; t++) begin
            step(t % 400 == 0, 1, 0);
            n_cmp++;
            if ((act & m_mask()) !== m_vec()) begin
                n_bad++; $display("FAIL basic cyc=%0d got %h exp %h", cyc, act, m_vec());
            end
        end
        n_cmp++;
        if (spinning_out !== 1'b1 || overrun_out !== 1'b0) begin
            n_bad++; $display("FAIL basic_flags got spin=%b ovr=%b exp spin=1 ovr=0", spinning_out, overrun_out);
        end
    endtask

    task automatic test_backpressure();
        int  hold = 0;
        bit  done = 0;
        bit  r;
        repeat (2) step(0, 0, 1);
        for (int t = 0; t <= 700; t++) begin
            if (hold > 0) begin
                r = 0; hold--;
            end else if (!done && q.size() > 0 && q[0] == 2) begin
                r = 0; hold = 9; done = 1;
            end else begin
                r = 1;
            end
            step(t % 400 == 0, r, 0);
            n_cmp++;
            if ((act & m_mask()) !== m_vec()) begin
                n_bad++; $display("FAIL backpressure cyc=%0d got %h exp %h", cyc, act, m_vec());
            end
            if (!r) begin
                n_cmp++;
                if (column_index1_out !== 2'd2 || column_index2_out !== 3'd5 || valid_out !== 1'b1) begin
                    n_bad++; $display("FAIL hold_pair cyc=%0d got (%0d,%0d) v=%b exp (2,5) v=1",
                                      cyc, column_index1_out, column_index2_out, valid_out);
                end
            end
        end
    endtask

    task automatic test_overrun();
        repeat (2) step(0, 0, 1);
        for (int t = 0; t <= 650; t++) begin
            step(t % 400 == 0, 0, 0);
            n_cmp++;
            if ((act & m_mask()) !== m_vec()) begin
                n_bad++; $display("FAIL overrun cyc=%0d got %h exp %h", cyc, act, m_vec());
            end
        end
        n_cmp++;
        if (overrun_out !== 1'b1 || dtheta_out !== 2'd2) begin
            n_bad++; $display("FAIL overrun_sticky got ovr=%b d=%0d exp ovr=1 d=2", overrun_out, dtheta_out);
        end
    endtask

    task automatic test_stall();
        repeat (2) step(0, 0, 1);
        for (int t = 0; t <= 2000; t++) begin
            step(t == 0 || t == 400 || t == 1500 || t == 1900, $urandom_range(0, 3) != 0, 0);
            n_cmp++;
            if ((act & m_mask()) !== m_vec()) begin
                n_bad++; $display("FAIL stall cyc=%0d got %h exp %h", cyc, act, m_vec());
            end
            if (t == 1499 || t == 1500) begin
                n_cmp++;
                if (spinning_out !== 1'b0 || valid_out !== 1'b0) begin
                    n_bad++; $display("FAIL stalled t=%0d got spin=%b v=%b exp 0 0", t, spinning_out, valid_out);
                end
            end
            if (t == 1900) begin
                n_cmp++;
                if (spinning_out !== 1'b1 || dtheta_out !== 2'd0 || valid_out !== 1'b1) begin
                    n_bad++; $display("FAIL resume got spin=%b d=%0d v=%b exp 1 0 1", spinning_out, dtheta_out, valid_out);
                end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit done = 0;
        bit rs;
        repeat (2) step(0, 0, 1);
        for (int t = 0; t <= 1300; t++) begin
            rs = !done && t > 400 && q.size() > 0 && q[0] == 2;
            if (rs) done = 1;
            step(!rs && (t % 400 == 0), 1, rs);
            n_cmp++;
            if (rs) begin
                if (act !== 10'h000) begin
                    n_bad++; $display("FAIL mid_reset got %h exp %h", act, 10'h000);
                end
            end else if ((act & m_mask()) !== m_vec()) begin
                n_bad++; $display("FAIL after_reset cyc=%0d got %h exp %h", cyc, act, m_vec());
            end
            if (t == 1199) begin
                n_cmp++;
                if (valid_out !== 1'b0 || spinning_out !== 1'b0 || !done) begin
                    n_bad++; $display("FAIL rearm got v=%b spin=%b reset_hit=%b exp 0 0 1", valid_out, spinning_out, done);
                end
            end
        end
    endtask

    task automatic test_random();
        int per;
        repeat (2) step(0, 0, 1);
        for (int rev = 0; rev < 14; rev++) begin
            per = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 12) : $urandom_range(40, 400);
            for (int t = 0; t < per; t++) begin
                step(t == 0, $urandom_range(0, 3) != 0, 0);
                n_cmp++;
                if ((act & m_mask()) !== m_vec()) begin
                    n_bad++; $display("FAIL random rev=%0d per=%0d cyc=%0d got %h exp %h", rev, per, cyc, act, m_vec());
                end
            end
        end
    endtask

`ifdef PHASE_OFFSET_EN
    task automatic test_phase_offset();
        int seq[4] = '{3, 0, 1, 2};
        phase_in = 3;
        repeat (2) step(0, 0, 1);
        for (int t = 0; t <= 1300; t++) begin
            if (t == 950) phase_in = $urandom_range(0, 3);
            step(t % 400 == 0, 1, 0);
            n_cmp++;
            if ((act & m_mask()) !== m_vec()) begin
                n_bad++; $display("FAIL phase cyc=%0d got %h exp %h", cyc, act, m_vec());
            end
            if (t >= 400 && t < 800 && t % 100 == 0) begin
                n_cmp++;
                if (dtheta_out !== 2'(seq[(t - 400) / 100])) begin
                    n_bad++; $display("FAIL phase_seq t=%0d got %0d exp %0d", t, dtheta_out, seq[(t - 400) / 100]);
                end
            end
        end
        phase_in = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_sweep();
        test_backpressure();
        test_overrun();
        test_stall();
        test_reset_mid_sweep();
        test_random();
`ifdef PHASE_OFFSET_EN
        test_phase_offset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d got no finish exp finish", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
